// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives imem address, tracks one-cycle read latency, 2-entry queue to decode.
// Optional stall counter output enabled by defining FETCH_STALL_CNT_EN.
module fetch_ctrl #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_data,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]        o_stall_count
`endif
);

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic [1:0]         r_count;
  logic [INSTR_W-1:0] r_q_instr [2];
  logic [ADDR_W-1:0]  r_q_pc    [2];

  logic       w_pop;
  logic       w_issue;
  logic [2:0] w_occ;

  assign o_imem_addr   = r_fetch_pc;
  assign o_instr_valid = (r_count != 2'd0);
  assign o_instr       = r_q_instr[0];
  assign o_instr_pc    = r_q_pc[0];

  always_comb begin
    w_pop   = o_instr_valid & i_instr_ready;
    w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
    w_issue = !i_redirect_valid &&
              (w_occ < (3'd2 + {2'b00, w_pop}));
  end

  // Slot 0 is the head; it is only overwritten on refill so it holds when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= 2'd0;
      r_q_instr[0]  <= '0;
      r_q_instr[1]  <= '0;
      r_q_pc[0]     <= '0;
      r_q_pc[1]     <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc <= i_redirect_pc;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_issue) begin
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
      end else begin
        r_inflight <= 1'b0;
      end
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_q_instr[0] <= i_imem_data;
            r_q_pc[0]    <= r_inflight_pc;
          end else begin
            r_q_instr[1] <= i_imem_data;
            r_q_pc[1]    <= r_inflight_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_q_instr[0] <= r_q_instr[1];
            r_q_pc[0]    <= r_q_pc[1];
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_q_instr[0] <= i_imem_data;
            r_q_pc[0]    <= r_inflight_pc;
          end else begin
            r_q_instr[0] <= r_q_instr[1];
            r_q_pc[0]    <= r_q_pc[1];
            r_q_instr[1] <= i_imem_data;
            r_q_pc[1]    <= r_inflight_pc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_count;
  assign o_stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_count <= 16'd0;
    else if (o_instr_valid && !i_instr_ready &&
             r_stall_count != 16'hFFFF)
      r_stall_count <= r_stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle vector table plus scoreboarded streaming sequences.
// Memory model returns 0x1000 + address one cycle after the address.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'h0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= 16'h1000 + {8'h00, imem_addr};

  fetch_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .o_imem_addr      (imem_addr),
    .i_imem_data      (imem_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .o_stall_count    (stall_count)
`endif
  );

  typedef struct {
    logic       rst, rdy, rv;
    logic [7:0] rpc;
    logic       chk, ev;
    logic [15:0] ei;
    logic [7:0] ep, ea;
    logic       cd;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] exp_q[$];

  function automatic vec_t mk(logic rst, logic rdy, logic rv,
                              logic [7:0] rpc, logic chk, logic ev,
                              logic [15:0] ei, logic [7:0] ep,
                              logic [7:0] ea, logic cd);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.chk = chk; v.ev = ev; v.ei = ei; v.ep = ep;
    v.ea = ea; v.cd = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst rdy rv rpc chk ev instr pc addr cd
    tbl.push_back(mk(1,1,0,8'h00,0,0,16'h0000,8'h00,8'h00,0));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'h00,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'h01,0));
    tbl.push_back(mk(0,1,0,8'h00,1,1,16'h1000,8'h00,8'h02,1));
    tbl.push_back(mk(0,1,0,8'h00,1,1,16'h1001,8'h01,8'h03,1));
    tbl.push_back(mk(0,0,0,8'h00,1,1,16'h1002,8'h02,8'h04,1));
    tbl.push_back(mk(0,0,0,8'h00,1,1,16'h1002,8'h02,8'h04,1));
    tbl.push_back(mk(0,1,0,8'h00,1,1,16'h1002,8'h02,8'h04,1));
    tbl.push_back(mk(0,1,0,8'h00,1,1,16'h1003,8'h03,8'h05,1));
    tbl.push_back(mk(0,1,1,8'h40,1,1,16'h1004,8'h04,8'h06,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'h40,0));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'h41,0));
    tbl.push_back(mk(0,1,1,8'hFE,1,1,16'h1040,8'h40,8'h42,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'hFE,0));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'hFF,0));
    tbl.push_back(mk(0,1,0,8'h00,1,1,16'h10FE,8'hFE,8'h00,1));
    tbl.push_back(mk(0,1,0,8'h00,1,1,16'h10FF,8'hFF,8'h01,1));
    tbl.push_back(mk(0,1,0,8'h00,1,1,16'h1000,8'h00,8'h02,1));
    tbl.push_back(mk(0,1,1,8'h10,1,1,16'h1001,8'h01,8'h03,1));
    tbl.push_back(mk(0,1,1,8'h20,1,0,16'h0000,8'h00,8'h10,0));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'h20,0));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'h21,0));
    tbl.push_back(mk(0,0,0,8'h00,1,1,16'h1020,8'h20,8'h22,1));
    tbl.push_back(mk(1,0,0,8'h00,1,1,16'h1020,8'h20,8'h22,1));
    tbl.push_back(mk(0,0,0,8'h00,1,0,16'h0000,8'h00,8'h00,1));
    tbl.push_back(mk(0,0,0,8'h00,1,0,16'h0000,8'h00,8'h01,0));
    tbl.push_back(mk(0,0,0,8'h00,1,1,16'h1000,8'h00,8'h02,1));
    tbl.push_back(mk(0,0,0,8'h00,1,1,16'h1000,8'h00,8'h02,1));
    tbl.push_back(mk(1,1,1,8'h80,1,1,16'h1000,8'h00,8'h02,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'h00,1));
    tbl.push_back(mk(0,1,0,8'h00,1,0,16'h0000,8'h00,8'h01,0));
    tbl.push_back(mk(0,1,0,8'h00,1,1,16'h1000,8'h00,8'h02,1));
    tbl.push_back(mk(0,1,0,8'h00,1,1,16'h1001,8'h01,8'h03,1));

    #1;
    foreach (tbl[i]) begin
      reset          = tbl[i].rst;
      instr_ready    = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d valid", i), instr_valid, tbl[i].ev);
        chk($sformatf("v%0d addr", i), imem_addr, tbl[i].ea);
        if (tbl[i].cd) begin
          chk($sformatf("v%0d instr", i), instr, tbl[i].ei);
          chk($sformatf("v%0d pc", i), instr_pc, tbl[i].ep);
        end
      end
      step();
    end

    // Stall from reset, then drain with no gaps.
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    step();
    reset = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("stall addr", imem_addr, 8'h02);
    chk("stall head pc", instr_pc, 8'h00);
    chk("stall head instr", instr, 16'h1000);
    step();
    for (int p = 0; p < 4; p++) exp_q.push_back(8'(p));
    instr_ready = 1'b1;
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      chk("drain no gap", instr_valid, 1'b1);
      if (instr_valid) begin
        chk("drain pc", instr_pc, exp_q[0]);
        chk("drain instr", instr, 16'h1000 + {8'h00, exp_q[0]});
        void'(exp_q.pop_front());
      end
      step();
    end
    chk("drain leftover", exp_q.size(), 0);
    exp_q.delete();

    // Redirect near the top of memory, random ready, wrap-around delivery.
    redirect_valid = 1'b1; redirect_pc = 8'hF0;
    step();
    redirect_valid = 1'b0;
    for (int p = 0; p < 40; p++) exp_q.push_back(8'(8'hF0 + p));
    for (int c = 0; c < 500 && exp_q.size() > 0; c++) begin
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        chk("stream pc", instr_pc, exp_q[0]);
        chk("stream instr", instr, 16'h1000 + {8'h00, exp_q[0]});
        void'(exp_q.pop_front());
      end
      step();
    end
    chk("stream leftover", exp_q.size(), 0);

`ifdef FETCH_STALL_CNT_EN
    reset = 1'b1; instr_ready = 1'b0;
    step();
    reset = 1'b0;
    begin
      int c;
      c = 0;
      @(negedge clk);
      while (!instr_valid && c < 10) begin
        @(negedge clk);
        c++;
      end
      chk("stall cnt valid seen", instr_valid, 1'b1);
      chk("stall cnt start", stall_count, 16'd0);
      repeat (10) @(negedge clk);
      chk("stall cnt ten", stall_count, 16'd10);
      @(posedge clk); #1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("stall cnt reset", stall_count, 16'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer between the program counter / instruction memory and the decode stage. It drives the instruction memory address, tracks the memory's one-cycle synchronous read latency, and buffers returned instructions with their PCs in a 2-entry queue. Decode pulls instructions through a valid/ready handshake. Branch/jump redirects flush all in-flight and buffered instructions.

Parameters:
ADDR_W, 8, width of the PC and instruction memory address (256 words)
INSTR_W, 16, instruction width
RESET_PC, 0, fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  ADDR_W  instruction memory address; combinational copy of fetch_pc
imem_data  input  INSTR_W  instruction memory read data; valid one cycle after the address is presented
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  ADDR_W  redirect target
instr_valid  output  1  head queue entry valid
instr_ready  input  1  decode accepts the head entry
instr  output  INSTR_W  head entry instruction
instr_pc  output  ADDR_W  head entry PC
stall_count  output  16  present only with FETCH_STALL_CNT_EN

Behaviour:
- Reset (reset=1 at an edge): fetch_pc=RESET_PC, inflight=0, count=0, queue cleared, instr_valid=0, instr=0, instr_pc=0. Reset overrides redirect and handshake. Asserting reset mid-stream drops all entries on the next cycle.
- pop = instr_valid & instr_ready.
- Issue: issue = !redirect_valid & (count + inflight - pop < 2). When issue=1: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 modulo 2^ADDR_W (0xFF -> 0x00). Otherwise inflight<=0 and fetch_pc holds. The memory reads every cycle regardless; unissued reads are ignored.
- Return: if inflight=1, imem_data and inflight_pc are pushed at the tail at the end of that cycle. The entry is visible on the outputs from the next cycle.
- Latency: address in cycle N, data in N+1, instr_valid in N+2. After reset release, the first instruction (pc=RESET_PC) is valid in cycle 2.
- Throughput: 1 instruction/cycle while instr_ready=1, with no bubbles after a stall ends.
- Queue: 2-entry FIFO, entries hold {instr, pc}. instr_valid = (count != 0); outputs show the head entry. A push and a pop in the same cycle leave count unchanged. Invariant: count + inflight <= 2 always; it is never possible to push into a full queue.
- Outputs hold their last head value when count=0.
- Redirect (redirect_valid=1 in cycle N): at the end of N, count<=0, inflight<=0 (data returning in N+1 is discarded), fetch_pc<=redirect_pc. Redirect beats pop; a pop in cycle N is still a legal handshake. instr_valid=0 in N+1 and N+2. redirect_pc is issued in N+1 and appears as the head entry in N+3.
- Back-to-back redirects: the last one wins; each restarts the sequence above.

Optional Feature:
FETCH_STALL_CNT_EN
- Defined: output stall_count (16 bits) counts cycles with instr_valid=1 & instr_ready=0. It saturates at 0xFFFF, resets to 0, and is unaffected by redirect.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Memory loaded with word i = 0x1000+i, release reset, instr_ready=1 -> cycle 2: instr_valid=1, instr=0x1000, instr_pc=0x00; then pcs 0x01, 0x02, … one per cycle, with no gaps.
- instr_ready=0 from reset -> queue holds pc 0 and pc 1, fetch_pc stops at 2, head stays 0x1000/0x00; raise ready -> pcs 0, 1, 2, 3 delivered in consecutive cycles.
- Steady streaming, redirect_valid=1 with redirect_pc=0x40 in cycle N -> instr_valid=0 in N+1 and N+2; N+3 shows instr=0x1040, pc=0x40; no pre-redirect instruction ever appears after N.
- Redirect to 0xFE, ready=1 -> delivered pcs 0xFE, 0xFF, 0x00, 0x01 with instr 0x10FE, 0x10FF, 0x1000, 0x1001.
- Queue full with ready=0, assert reset for 1 cycle -> instr_valid=0 the next cycle; the first instr after release is pc=RESET_PC, 2 cycles later.
- FETCH_STALL_CNT_EN defined, ready held low for 10 cycles with the queue valid -> stall_count=10; reset -> 0.
